// File: rtl/alu_issue_pkg.sv
// Shared ALU encodings, RISC-V opcode constants and the issue bundle layout
// used by the decoder, the issue buffer and the downstream ALU.
package alu_issue_pkg;

  typedef enum logic [3:0] {
    ALU_ADD     = 4'b0000,
    ALU_SUB     = 4'b0001,
    ALU_SLL     = 4'b0010,
    ALU_XOR     = 4'b0011,
    ALU_SRL     = 4'b0100,
    ALU_SRA     = 4'b0101,
    ALU_OR      = 4'b0110,
    ALU_AND     = 4'b0111,
    ALU_LUIPASS = 4'b1000
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    FLAG_EQ  = 3'b000,
    FLAG_NE  = 3'b001,
    FLAG_LT  = 3'b010,
    FLAG_GE  = 3'b011,
    FLAG_LTU = 3'b100,
    FLAG_GEU = 3'b101
  } flag_sel_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } buf_state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    alu_ctrl_e   alu_ctrl;
    flag_sel_e   flag_sel;
    logic [4:0]  rd;
    logic        wb_en;
    logic        is_branch;
    logic        set_flag;
    logic        illegal;
  } issue_bundle_t;

  // Shared funct3 -> operation map of OP and OP-IMM; SLT/SLTU compute via SUB.
  function automatic alu_ctrl_e base_alu_op(input logic [2:0] funct3);
    case (funct3)
      3'b000:         return ALU_ADD;
      3'b001:         return ALU_SLL;
      3'b010, 3'b011: return ALU_SUB;
      3'b100:         return ALU_XOR;
      3'b101:         return ALU_SRL;
      3'b110:         return ALU_OR;
      default:        return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of one RV32I integer instruction into an issue bundle.
module alu_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0]   instr,
  input  logic [31:0]   pc,
  input  logic [31:0]   rs1_data,
  input  logic [31:0]   rs2_data,
  output issue_bundle_t bundle
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       legal;
  logic       unused_rs1_idx;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  // Register indices are resolved upstream; only the data arrives here.
  assign unused_rs1_idx = ^instr[19:15];

  always_comb begin
    bundle    = '0;
    bundle.rd = instr[11:7];
    legal     = 1'b0;
    case (opcode)
      OPC_OP: begin
        bundle.operand_a = rs1_data;
        bundle.operand_b = rs2_data;
        if (funct7 == F7_BASE) begin
          legal           = 1'b1;
          bundle.alu_ctrl = base_alu_op(funct3);
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          legal           = 1'b1;
          bundle.alu_ctrl = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          legal           = 1'b1;
          bundle.alu_ctrl = ALU_SRA;
        end
      end
      OPC_OP_IMM: begin
        bundle.operand_a = rs1_data;
        bundle.operand_b = {{20{instr[31]}}, instr[31:20]};
        case (funct3)
          3'b001: begin
            bundle.operand_b = {27'b0, instr[24:20]};
            legal            = (funct7 == F7_BASE);
            bundle.alu_ctrl  = ALU_SLL;
          end
          3'b101: begin
            bundle.operand_b = {27'b0, instr[24:20]};
            legal            = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            bundle.alu_ctrl  = instr[30] ? ALU_SRA : ALU_SRL;
          end
          default: begin
            legal           = 1'b1;
            bundle.alu_ctrl = base_alu_op(funct3);
          end
        endcase
      end
      OPC_LUI: begin
        legal            = 1'b1;
        bundle.operand_b = {12'b0, instr[31:12]};
        bundle.alu_ctrl  = ALU_LUIPASS;
      end
      OPC_AUIPC: begin
        legal            = 1'b1;
        bundle.operand_a = pc;
        bundle.operand_b = {instr[31:12], 12'h000};
      end
      OPC_BRANCH: begin
        legal            = 1'b1;
        bundle.operand_a = rs1_data;
        bundle.operand_b = rs2_data;
        bundle.alu_ctrl  = ALU_SUB;
        bundle.is_branch = 1'b1;
        bundle.rd        = '0;
        case (funct3)
          3'b000:  bundle.flag_sel = FLAG_EQ;
          3'b001:  bundle.flag_sel = FLAG_NE;
          3'b100:  bundle.flag_sel = FLAG_LT;
          3'b101:  bundle.flag_sel = FLAG_GE;
          3'b110:  bundle.flag_sel = FLAG_LTU;
          3'b111:  bundle.flag_sel = FLAG_GEU;
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase

    if ((opcode == OPC_OP || opcode == OPC_OP_IMM) && funct3[2:1] == 2'b01) begin
      bundle.set_flag = 1'b1;
      if (funct3[0]) bundle.flag_sel = FLAG_LTU;
      else           bundle.flag_sel = FLAG_LT;
    end

    if (!legal) begin
      bundle         = '0;
      bundle.illegal = 1'b1;
    end else begin
      bundle.wb_en = !bundle.is_branch && (bundle.rd != '0);
    end
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes incoming instructions and holds them in a
// two-entry skid buffer (main, skid) in front of the ALU.
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] operand_a_o,
  output logic [31:0] operand_b_o,
  output logic [3:0]  alu_ctrl_o,
  output logic [2:0]  flag_sel_o,
  output logic [4:0]  rd_o,
  output logic        wb_en_o,
  output logic        is_branch_o,
  output logic        set_flag_o,
  output logic        illegal_o
);

  issue_bundle_t dec_bundle;
  issue_bundle_t main_q;
  issue_bundle_t skid_q;
  buf_state_e    state_q;
  buf_state_e    state_d;
  logic          accept;
  logic          drain;

  alu_decode u_decode (
    .instr    (instr_i),
    .pc       (pc_i),
    .rs1_data (rs1_data_i),
    .rs2_data (rs2_data_i),
    .bundle   (dec_bundle)
  );

  assign out_valid_o = (state_q != ST_EMPTY);
  assign accept      = in_valid_i && in_ready_o;
  assign drain       = out_valid_o && out_ready_i;

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) state_d = ST_ONE;
        ST_ONE: begin
          if (accept && !drain)      state_d = ST_TWO;
          else if (!accept && drain) state_d = ST_EMPTY;
        end
        ST_TWO:   if (drain) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // in_ready is the registered image of "next state has a free slot".
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_EMPTY;
      in_ready_o <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_o <= (state_d != ST_TWO);
      if (!flush_i) begin
        case (state_q)
          ST_EMPTY: if (accept) main_q <= dec_bundle;
          ST_ONE: begin
            if (accept && drain) main_q <= dec_bundle;
            else if (accept)     skid_q <= dec_bundle;
          end
          ST_TWO:   if (drain) main_q <= skid_q;
          default: ;
        endcase
      end
    end
  end

  assign operand_a_o = main_q.operand_a;
  assign operand_b_o = main_q.operand_b;
  assign alu_ctrl_o  = main_q.alu_ctrl;
  assign flag_sel_o  = main_q.flag_sel;
  assign rd_o        = main_q.rd;
  assign wb_en_o     = main_q.wb_en;
  assign is_branch_o = main_q.is_branch;
  assign set_flag_o  = main_q.set_flag;
  assign illegal_o   = main_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: queue-based reference model plus
// directed literal scenarios and a randomized traffic phase.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] instr_i = '0;
  logic [31:0] pc_i = '0;
  logic [31:0] rs1_data_i = '0;
  logic [31:0] rs2_data_i = '0;
  logic        flush_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] operand_a_o;
  logic [31:0] operand_b_o;
  logic [3:0]  alu_ctrl_o;
  logic [2:0]  flag_sel_o;
  logic [4:0]  rd_o;
  logic        wb_en_o;
  logic        is_branch_o;
  logic        set_flag_o;
  logic        illegal_o;

  alu_issue dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .instr_i     (instr_i),
    .pc_i        (pc_i),
    .rs1_data_i  (rs1_data_i),
    .rs2_data_i  (rs2_data_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .operand_a_o (operand_a_o),
    .operand_b_o (operand_b_o),
    .alu_ctrl_o  (alu_ctrl_o),
    .flag_sel_o  (flag_sel_o),
    .rd_o        (rd_o),
    .wb_en_o     (wb_en_o),
    .is_branch_o (is_branch_o),
    .set_flag_o  (set_flag_o),
    .illegal_o   (illegal_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [2:0]  fs;
    logic [4:0]  rd;
    logic        wb;
    logic        br;
    logic        sf;
    logic        ill;
  } exp_t;

  int n_pass = 0;
  int n_total = 0;
  int delivered[$];
  logic [3:0] base_tab [8] = '{4'd0, 4'd2, 4'd1, 4'd1, 4'd3, 4'd4, 4'd6, 4'd7};

  exp_t model_q[$];
  logic ready_m = 1'b0;
  logic zero_main = 1'b1;

  task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, got, exp);
  endtask

  // Expected bundle straight from the RV32I field rules.
  function automatic exp_t model_dec(input logic [31:0] ins, input logic [31:0] pc,
                                     input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    logic ok;
    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    e = '0;
    ok = 1'b0;
    e.rd = ins[11:7];
    if (op == 7'h33) begin
      e.a = r1;
      e.b = r2;
      if (f7 == 7'h00) begin ok = 1'b1; e.ctrl = base_tab[f3]; end
      else if (f7 == 7'h20 && f3 == 3'd0) begin ok = 1'b1; e.ctrl = 4'd1; end
      else if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1'b1; e.ctrl = 4'd5; end
    end else if (op == 7'h13) begin
      e.a = r1;
      e.b = {{20{ins[31]}}, ins[31:20]};
      if (f3 == 3'd1) begin
        e.b = 32'(ins[24:20]); ok = (f7 == 7'h00); e.ctrl = 4'd2;
      end else if (f3 == 3'd5) begin
        e.b = 32'(ins[24:20]); ok = (f7 == 7'h00 || f7 == 7'h20);
        e.ctrl = (f7 == 7'h20) ? 4'd5 : 4'd4;
      end else begin
        ok = 1'b1; e.ctrl = base_tab[f3];
      end
    end else if (op == 7'h37) begin
      ok = 1'b1; e.b = 32'(ins[31:12]); e.ctrl = 4'd8;
    end else if (op == 7'h17) begin
      ok = 1'b1; e.a = pc; e.b = ins[31:12] * 32'h1000; e.ctrl = 4'd0;
    end else if (op == 7'h63) begin
      ok = (f3 != 3'd2 && f3 != 3'd3);
      e.a = r1; e.b = r2; e.ctrl = 4'd1; e.br = 1'b1;
      e.fs = (f3 < 3'd4) ? f3 : f3 - 3'd2;
    end
    if ((op == 7'h33 || op == 7'h13) && (f3 == 3'd2 || f3 == 3'd3)) begin
      e.sf = 1'b1;
      e.fs = (f3 == 3'd2) ? 3'd2 : 3'd4;
    end
    if (!ok) begin
      e = '0;
      e.ill = 1'b1;
    end else begin
      e.wb = !e.br && (e.rd != 5'd0);
    end
    return e;
  endfunction

  function automatic logic [79:0] pack_exp(input exp_t e);
    return {e.a, e.b, e.ctrl, e.fs, (e.br || e.ill) ? 5'd0 : e.rd, e.wb, e.br, e.sf, e.ill};
  endfunction

  function automatic logic [79:0] dut_vec(input logic mask_rd);
    return {operand_a_o, operand_b_o, alu_ctrl_o, flag_sel_o, mask_rd ? 5'd0 : rd_o,
            wb_en_o, is_branch_o, set_flag_o, illegal_o};
  endfunction

  // Compare outputs, then advance the model with the inputs the next edge samples.
  initial begin : compare
    logic acc;
    logic dr;
    exp_t nxt;
    forever begin
      @(negedge clk);
      check("out_valid", 80'(out_valid_o), 80'(model_q.size() != 0));
      check("in_ready", 80'(in_ready_o), 80'(ready_m));
      if (model_q.size() != 0)
        check("bundle", dut_vec(model_q[0].br || model_q[0].ill), pack_exp(model_q[0]));
      else if (zero_main)
        check("bundle_zero", dut_vec(1'b0), '0);
      if (out_valid_o && out_ready_i && !rst_i && !flush_i) delivered.push_back(int'(rd_o));
      if (rst_i) begin
        model_q.delete(); ready_m = 1'b0; zero_main = 1'b1;
      end else if (flush_i) begin
        model_q.delete(); ready_m = 1'b1;
      end else begin
        acc = in_valid_i && ready_m;
        dr  = (model_q.size() != 0) && out_ready_i;
        nxt = model_dec(instr_i, pc_i, rs1_data_i, rs2_data_i);
        if (dr) void'(model_q.pop_front());
        if (acc) begin model_q.push_back(nxt); zero_main = 1'b0; end
        ready_m = (model_q.size() < 2);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] p,
                      input logic [31:0] a, input logic [31:0] b);
    int unsigned n;
    logic acc;
    instr_i = ins; pc_i = p; rs1_data_i = a; rs2_data_i = b; in_valid_i = 1'b1;
    n = 0;
    do begin
      acc = in_ready_o;
      tick();
      n++;
    end while (!acc && n < 30);
    if (!acc) begin
      n_total++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0] f7_pick [4];
    r = $urandom;
    f7_pick = '{7'h00, 7'h00, 7'h20, 7'h01};
    case ($urandom_range(0, 7))
      0, 1: begin r[6:0] = 7'h33; r[31:25] = ($urandom_range(0, 4) == 0) ? 7'($urandom) : f7_pick[$urandom_range(0, 3)]; end
      2, 3: begin
        r[6:0] = 7'h13;
        if (r[13:12] == 2'b01) r[31:25] = ($urandom_range(0, 3) == 0) ? 7'($urandom) : f7_pick[$urandom_range(0, 2)];
      end
      4: r[6:0] = 7'h37;
      5: r[6:0] = 7'h17;
      6: r[6:0] = 7'h63;
      default: ;
    endcase
    return r;
  endfunction

  initial begin : main
    repeat (3) tick();
    check("rst_in_ready", 80'(in_ready_o), 80'(0));
    check("rst_out_valid", 80'(out_valid_o), 80'(0));
    check("rst_bundle", dut_vec(1'b0), '0);
    rst_i = 1'b0;
    tick();
    check("post_rst_in_ready", 80'(in_ready_o), 80'(1));

    out_ready_i = 1'b1;
    send({12'hFFF, 5'd1, 3'b000, 5'd5, 7'h13}, 32'h0, 32'd5, 32'd0);
    in_valid_i = 1'b0;
    check("addi", {out_valid_o, operand_a_o, operand_b_o, alu_ctrl_o, rd_o, wb_en_o},
          {1'b1, 32'd5, 32'hFFFF_FFFF, 4'b0000, 5'd5, 1'b1});
    tick();
    send({7'b0, 5'd2, 5'd1, 3'b110, 5'd0, 7'h63}, 32'h0, 32'd1, 32'd2);
    in_valid_i = 1'b0;
    check("bltu", {alu_ctrl_o, flag_sel_o, is_branch_o, wb_en_o}, {4'b0001, 3'b100, 1'b1, 1'b0});
    tick();
    send({20'h12345, 5'd1, 7'h37}, 32'h0, 32'hDEAD, 32'hBEEF);
    in_valid_i = 1'b0;
    check("lui", {operand_b_o, alu_ctrl_o}, {32'h0001_2345, 4'b1000});
    tick();
    send({20'h00001, 5'd2, 7'h17}, 32'h100, 32'h0, 32'h0);
    in_valid_i = 1'b0;
    check("auipc", {operand_a_o, operand_b_o, alu_ctrl_o}, {32'h100, 32'h1000, 4'b0000});
    tick();
    send({12'h0, 5'd1, 3'b010, 5'd3, 7'b0000011}, 32'h0, 32'd7, 32'd9);
    in_valid_i = 1'b0;
    check("illegal_load", {illegal_o, wb_en_o, operand_a_o}, {1'b1, 1'b0, 32'h0});
    tick();
    send({7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33}, 32'h0, 32'd7, 32'd9);
    in_valid_i = 1'b0;
    check("illegal_mul", {illegal_o, wb_en_o}, {1'b1, 1'b0});
    repeat (2) tick();

    // Four ADDIs into a stalled consumer: in_ready drops after two accepts.
    delivered.delete();
    out_ready_i = 1'b0;
    send({12'd1, 5'd0, 3'b000, 5'd1, 7'h13}, 32'h0, 32'h0, 32'h0);
    check("stream_ready_after_1", 80'(in_ready_o), 80'(1));
    send({12'd2, 5'd0, 3'b000, 5'd2, 7'h13}, 32'h0, 32'h0, 32'h0);
    check("stream_ready_after_2", 80'(in_ready_o), 80'(0));
    instr_i = {12'd3, 5'd0, 3'b000, 5'd3, 7'h13};
    tick();
    out_ready_i = 1'b1;
    send({12'd3, 5'd0, 3'b000, 5'd3, 7'h13}, 32'h0, 32'h0, 32'h0);
    send({12'd4, 5'd0, 3'b000, 5'd4, 7'h13}, 32'h0, 32'h0, 32'h0);
    in_valid_i = 1'b0;
    repeat (4) tick();
    check("stream_count", 80'(delivered.size()), 80'(4));
    for (int i = 0; i < 4 && i < delivered.size(); i++)
      check("stream_order", 80'(delivered[i]), 80'(i + 1));

    // Flush while full with a new input offered.
    out_ready_i = 1'b0;
    send({12'd7, 5'd0, 3'b000, 5'd7, 7'h13}, 32'h0, 32'h0, 32'h0);
    send({12'd8, 5'd0, 3'b000, 5'd8, 7'h13}, 32'h0, 32'h0, 32'h0);
    instr_i = {12'd9, 5'd0, 3'b000, 5'd9, 7'h13};
    in_valid_i = 1'b1;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    check("flush_out_valid", 80'(out_valid_o), 80'(0));
    check("flush_in_ready", 80'(in_ready_o), 80'(1));
    delivered.delete();
    out_ready_i = 1'b1;
    repeat (4) tick();
    check("flush_nothing_delivered", 80'(delivered.size()), 80'(0));

    // Reset in the middle of traffic.
    out_ready_i = 1'b0;
    send({12'd10, 5'd0, 3'b000, 5'd10, 7'h13}, 32'h0, 32'h0, 32'h0);
    send({12'd11, 5'd0, 3'b000, 5'd11, 7'h13}, 32'h0, 32'h0, 32'h0);
    rst_i = 1'b1;
    tick();
    check("midrst_out_valid", 80'(out_valid_o), 80'(0));
    check("midrst_in_ready", 80'(in_ready_o), 80'(0));
    rst_i = 1'b0;
    in_valid_i = 1'b0;
    tick();
    check("midrst_recover_ready", 80'(in_ready_o), 80'(1));

    for (int c = 0; c < 3000; c++) begin
      in_valid_i  = ($urandom_range(0, 9) < 7);
      out_ready_i = ($urandom_range(0, 9) < 6);
      flush_i     = ($urandom_range(0, 99) < 3);
      rst_i       = ($urandom_range(0, 199) == 0);
      instr_i     = rand_instr();
      pc_i        = $urandom;
      rs1_data_i  = $urandom;
      rs2_data_i  = $urandom;
      tick();
    end
    in_valid_i = 1'b0;
    flush_i = 1'b0;
    rst_i = 1'b0;
    out_ready_i = 1'b1;
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have clk_i, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have rst_i, input, 1, synchronous active-high reset.
REQ-003 SHALL have in_valid_i/in_ready_o, input/output, 1 each, upstream handshake; in_ready_o driven from a flop.
REQ-004 SHALL have instr_i, pc_i, rs1_data_i, rs2_data_i, input, 32 each, instruction word, its PC, register operands.
REQ-005 SHALL have flush_i, input, 1, discard all held entries.
REQ-006 SHALL have out_valid_o/out_ready_i, output/input, 1 each, downstream (ALU stage) handshake.
REQ-007 SHALL have operand_a_o, operand_b_o, output, 32 each, ALU operands.
REQ-008 SHALL have alu_ctrl_o (4) and flag_sel_o (3), outputs, ALU operation and compare-flag select.
REQ-009 SHALL have rd_o (5), wb_en_o, is_branch_o, set_flag_o, illegal_o, outputs: destination, writeback enable, branch marker, "write flag as result" (SLT/SLTU), undecodable marker.

Function
REQ-010 alu_ctrl encodings SHALL be ADD 0000, SUB 0001, SLL 0010, XOR 0011, SRL 0100, SRA 0101, OR 0110, AND 0111, LUIPASS 1000 (B<<12).
REQ-011 flag_sel encodings SHALL be EQ 000, NE 001, LT 010, GE 011, LTU 100, GEU 101.
REQ-012 OP (0110011): A=rs1, B=rs2; funct7 0000000 with funct3 ADD/SLL/XOR/SRL/OR/AND; 0100000 with SUB(000)/SRA(101); SLT->SUB+LT, SLTU->SUB+LTU, set_flag=1.
REQ-013 OP-IMM (0010011): A=rs1, B=sign-extended instr[31:20]; shifts use B=zero-extended instr[24:20], SRAI when instr[30]=1; SLTI/SLTIU as REQ-012.
REQ-014 LUI (0110111): A=0, B=zero-extended instr[31:12], LUIPASS; AUIPC (0010111): A=pc_i, B={instr[31:12],12'h000}, ADD.
REQ-015 BRANCH (1100011): A=rs1, B=rs2, SUB, is_branch=1, wb_en=0; funct3 000/001/100/101/110/111 -> EQ/NE/LT/GE/LTU/GEU; 010/011 illegal.
REQ-016 Any other opcode or disallowed funct7/funct3 SHALL set illegal_o=1, wb_en=0, alu_ctrl=ADD, operands 0; it is still issued.
REQ-017 wb_en SHALL be 1 for legal OP/OP-IMM/LUI/AUIPC with rd!=0, else 0; flag_sel SHALL be 000 for non-compare instructions.
REQ-018 Decoding SHALL be combinational on input; the decoded bundle is stored in a 2-entry skid buffer (main, skid).
REQ-019 States: EMPTY, ONE (main valid), TWO (main+skid valid); out_valid_o=1 in ONE/TWO; outputs always present main.
REQ-020 Transitions: accept only when in_valid_i&&in_ready_o; drain when out_valid_o&&out_ready_i; EMPTY+accept->ONE; ONE+accept+drain->ONE (main replaced); ONE+accept only->TWO (skid loaded); ONE+drain only->EMPTY; TWO+drain->ONE (skid moves to main); TWO never accepts.
REQ-021 in_ready_o SHALL be registered, equal to 1 in next state EMPTY/ONE, 0 in TWO; latency input-accept to out_valid_o = 1 cycle; sustained throughput 1/cycle.
REQ-022 Bundle on outputs SHALL remain stable while out_valid_o=1 and out_ready_i=0.
REQ-023 flush_i SHALL win over all: next state EMPTY, any simultaneous accept dropped, in_ready_o=1 next cycle.
REQ-024 Instruction order SHALL be preserved; no entry duplicated or lost without flush.

Reset
REQ-025 rst_i SHALL force EMPTY, out_valid_o=0, in_ready_o=0 during reset and 1 the first cycle after, all bundle outputs 0, regardless of in-flight traffic.

Structure
REQ-026 ALU_CTRL and FLAG_SEL encodings, RISC-V opcode constants and the bundle struct SHALL live in a shared package used also by the ALU.
REQ-027 Decode SHALL be one combinational sub-module alu_decode (instr, pc, rs1, rs2 -> bundle); alu_issue holds the buffer FSM.

Verification
REQ-028 ADDI x5,x1,-1 with rs1=5 -> next cycle A=5, B=FFFFFFFF, ctrl 0000, rd=5, wb_en=1.
REQ-029 BLTU funct3 110, rs1=1, rs2=2 -> ctrl 0001, flag_sel 100, is_branch=1, wb_en=0.
REQ-030 LUI 0x12345 -> B=00012345, ctrl 1000; AUIPC 0x1 at pc 0x100 -> A=100, B=1000, ctrl 0000.
REQ-031 Stream 4 instrs with out_ready_i=0 for 3 cycles -> in_ready_o falls after 2 accepts, all 4 delivered in order once ready=1.
REQ-032 flush_i in state TWO with in_valid_i=1 -> out_valid_o=0 next cycle, flushed input not delivered.
REQ-033 opcode 0000011 or OP funct7 0000001 -> illegal_o=1, wb_en=0; rst_i mid-stream -> out_valid_o=0 next cycle.
